// File: rtl/cmd_frame_assembler.sv
// cmd_frame_assembler
//   Builds one command from an SPI byte stream. The first byte of a frame is
//   the opcode, and up to DATA_BYTES payload bytes follow it. A frame closes
//   on frame_end, or after GAP_CYCLES consecutive idle cycles when GAP_CYCLES
//   is nonzero. At close the opcode is classified as read, camwrite or mem.
//   A good frame is registered onto instruction/data, and the matching class
//   valid is held until out_ack. A bad frame gives a one-cycle frame_err.
//
//   Optional build macro:
//     CMD_FRAME_LEN_CHECK_EN -- reject any frame whose byte count (opcode
//     included) is not DATA_BYTES+1. Without this macro, a short frame is
//     delivered zero-padded and an over-length frame is delivered truncated.
module cmd_frame_assembler #(
    parameter int DATA_BYTES = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                    sysClk,
    input  logic                    reset,
    input  logic [7:0]              byte_in,
    input  logic                    rx_valid,
    input  logic                    frame_end,
    input  logic                    out_ack,
    output logic [7:0]              instruction,
    output logic [DATA_BYTES*8-1:0] data,
    output logic                    valid_buffer_for_camwrite,
    output logic                    valid_buffer_for_read,
    output logic                    valid_buffer_for_mem,
    output logic                    frame_err,
    output logic                    rx_drop
);

    // The byte count saturates one above a full frame. An over-length frame
    // therefore stays distinguishable from an exact-length frame, however long
    // it runs.
    localparam int CNT_MAX_I = DATA_BYTES + 2;
    localparam int CNT_W     = $clog2(CNT_MAX_I + 1);
    localparam int GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_MAX_I);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DELIVER
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_READ,
        CLS_CAMWRITE,
        CLS_MEM
    } cmd_class_t;

    // Maps an opcode to its command class. Unlisted opcodes map to CLS_NONE.
    function automatic cmd_class_t classify(input logic [7:0] op);
        case (op)
            8'h00, 8'h02:                             classify = CLS_READ;
            8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0B: classify = CLS_CAMWRITE;
            8'h07, 8'h08, 8'h09, 8'h0A:               classify = CLS_MEM;
            default:                                  classify = CLS_NONE;
        endcase
    endfunction

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              opcode_q;
    logic [CNT_W-1:0]        byte_cnt;
    logic [CNT_W-1:0]        cnt_final;
    logic [GAP_W-1:0]        gap_cnt;
    logic [7:0]              payload      [DATA_BYTES];
    logic [7:0]              payload_next [DATA_BYTES];
    logic [DATA_BYTES*8-1:0] data_next;
    cmd_class_t              opcode_class;
    logic                    gap_hit;
    logic                    len_ok;

    // Control strobes from the FSM to the datapath.
    logic start_frame;
    logic accept_byte;
    logic deliver_cmd;
    logic reject_cmd;
    logic release_cmd;
    logic drop_byte;

    assign opcode_class = classify(opcode_q);

    // Count after this cycle. A byte that arrives in the closing cycle is
    // part of the frame, so the length check has to see it.
    assign cnt_final = (rx_valid && (byte_cnt != CNT_MAX)) ? byte_cnt + CNT_ONE : byte_cnt;

`ifdef CMD_FRAME_LEN_CHECK_EN
    assign len_ok = (cnt_final == CNT_FULL);
`else
    assign len_ok = 1'b1;
`endif

    // The timeout fires in the idle cycle that brings the gap count up to
    // GAP_CYCLES. The frame therefore closes after exactly GAP_CYCLES idle cycles.
    generate
        if (GAP_CYCLES > 0) begin : g_gap
            localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
            assign gap_hit = !rx_valid && (gap_cnt == GAP_LAST);
        end else begin : g_no_gap
            assign gap_hit = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    // Next-state decode and control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_next  = state;
        start_frame = 1'b0;
        accept_byte = 1'b0;
        deliver_cmd = 1'b0;
        reject_cmd  = 1'b0;
        release_cmd = 1'b0;
        drop_byte   = 1'b0;

        case (state)
            IDLE: begin
                // frame_end is meaningless before a frame starts.
                if (rx_valid) begin
                    start_frame = 1'b1;
                    state_next  = COLLECT;
                end
            end

            COLLECT: begin
                accept_byte = rx_valid;
                if (frame_end || gap_hit) begin
                    if (len_ok && (opcode_class != CLS_NONE)) begin
                        deliver_cmd = 1'b1;
                        state_next  = DELIVER;
                    end else begin
                        reject_cmd = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            DELIVER: begin
                // Bytes are never queued behind a pending command. A byte in
                // the acknowledge cycle is dropped too.
                drop_byte = rx_valid;
                if (out_ack) begin
                    release_cmd = 1'b1;
                    state_next  = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Payload buffer update and packing. Index 0 lands in the data MSBs.
    always_comb begin
        payload_next = payload;
        if (start_frame) begin
            payload_next = '{default: 8'h00};
        end else if (accept_byte) begin
            // Payload index is byte_cnt-1. Bytes past DATA_BYTES match no slot
            // and are discarded.
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (byte_cnt == CNT_W'(i + 1)) begin
                    payload_next[i] = byte_in;
                end
            end
        end

        data_next = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            data_next[(DATA_BYTES - 1 - i) * 8 +: 8] = payload_next[i];
        end
    end

    // Frame datapath: opcode, counters, payload buffer and registered outputs.
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            opcode_q                  <= 8'h00;
            byte_cnt                  <= '0;
            gap_cnt                   <= '0;
            // NOTE: the payload buffer is small, and its contents after reset
            // are observable (zero padding), so it is reset like any other
            // register rather than left as unreset RAM.
            payload                   <= '{default: 8'h00};
            instruction               <= 8'h00;
            data                      <= '0;
            valid_buffer_for_camwrite <= 1'b0;
            valid_buffer_for_read     <= 1'b0;
            valid_buffer_for_mem      <= 1'b0;
            frame_err                 <= 1'b0;
            rx_drop                   <= 1'b0;
        end else begin
            frame_err <= reject_cmd;
            rx_drop   <= drop_byte;
            payload   <= payload_next;

            if (start_frame) begin
                opcode_q <= byte_in;
                byte_cnt <= CNT_ONE;
                gap_cnt  <= '0;
            end else if (state == COLLECT) begin
                byte_cnt <= cnt_final;
                if (rx_valid) begin
                    gap_cnt <= '0;
                end else if (gap_cnt != GAP_MAX) begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
            end

            if (deliver_cmd) begin
                instruction               <= opcode_q;
                data                      <= data_next;
                valid_buffer_for_camwrite <= (opcode_class == CLS_CAMWRITE);
                valid_buffer_for_read     <= (opcode_class == CLS_READ);
                valid_buffer_for_mem      <= (opcode_class == CLS_MEM);
            end else if (release_cmd) begin
                valid_buffer_for_camwrite <= 1'b0;
                valid_buffer_for_read     <= 1'b0;
                valid_buffer_for_mem      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// tb_cmd_frame_assembler
//   Directed and randomized frames against a byte-queue reference model.
//   The main instance uses the default parameters. A second instance uses
//   DATA_BYTES=2 and GAP_CYCLES=0.
//   Expectations follow the CMD_FRAME_LEN_CHECK_EN build macro when it is set.
module tb_cmd_frame_assembler;

    localparam int DB  = 8;
    localparam int GAP = 4;
`ifdef CMD_FRAME_LEN_CHECK_EN
    localparam bit LEN_CHECK = 1'b1;
`else
    localparam bit LEN_CHECK = 1'b0;
`endif

    logic          sysClk = 1'b0;
    logic          reset;

    logic [7:0]    byte_in;
    logic          rx_valid;
    logic          frame_end;
    logic          out_ack;
    logic [7:0]    instruction;
    logic [DB*8-1:0] data;
    logic          v_cam, v_read, v_mem;
    logic          frame_err;
    logic          rx_drop;

    logic [7:0]    b2_byte;
    logic          b2_rx_valid;
    logic          b2_frame_end;
    logic          b2_out_ack;
    logic [7:0]    b2_instruction;
    logic [15:0]   b2_data;
    logic          b2_cam, b2_read, b2_mem;
    logic          b2_err;
    logic          b2_drop;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: the bytes of the current frame and the result.
    logic [7:0]  frame_q[$];
    logic [2:0]  exp_v;     // {camwrite, read, mem}
    logic [63:0] exp_d;
    logic        exp_e;
    logic [7:0]  exp_op;

    cmd_frame_assembler #(.DATA_BYTES(DB), .GAP_CYCLES(GAP)) dut (
        .sysClk                    (sysClk),
        .reset                     (reset),
        .byte_in                   (byte_in),
        .rx_valid                  (rx_valid),
        .frame_end                 (frame_end),
        .out_ack                   (out_ack),
        .instruction               (instruction),
        .data                      (data),
        .valid_buffer_for_camwrite (v_cam),
        .valid_buffer_for_read     (v_read),
        .valid_buffer_for_mem      (v_mem),
        .frame_err                 (frame_err),
        .rx_drop                   (rx_drop)
    );

    cmd_frame_assembler #(.DATA_BYTES(2), .GAP_CYCLES(0)) dut2 (
        .sysClk                    (sysClk),
        .reset                     (reset),
        .byte_in                   (b2_byte),
        .rx_valid                  (b2_rx_valid),
        .frame_end                 (b2_frame_end),
        .out_ack                   (b2_out_ack),
        .instruction               (b2_instruction),
        .data                      (b2_data),
        .valid_buffer_for_camwrite (b2_cam),
        .valid_buffer_for_read     (b2_read),
        .valid_buffer_for_mem      (b2_mem),
        .frame_err                 (b2_err),
        .rx_drop                   (b2_drop)
    );

    always #5 sysClk = ~sysClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge sysClk);
        #1;
    endtask

    // Class bits {camwrite, read, mem} from the opcode table.
    function automatic logic [2:0] class_bits(input logic [7:0] op);
        if (op == 8'h00 || op == 8'h02) return 3'b010;
        if (op == 8'h01 || op == 8'h0B || (op >= 8'h03 && op <= 8'h06)) return 3'b100;
        if (op >= 8'h07 && op <= 8'h0A) return 3'b001;
        return 3'b000;
    endfunction

    // Expected outcome of the frame held in frame_q (main instance).
    task automatic model_frame();
        logic [2:0] cls;
        logic       bad_len;
        cls     = class_bits(frame_q[0]);
        bad_len = LEN_CHECK && (frame_q.size() != DB + 1);
        exp_op  = frame_q[0];
        exp_d   = '0;
        for (int i = 1; i < frame_q.size() && i <= DB; i++) begin
            exp_d[(DB - i) * 8 +: 8] = frame_q[i];
        end
        exp_e = (cls == 3'b000) || bad_len;
        exp_v = exp_e ? 3'b000 : cls;
    endtask

    // Sends frame_q to the main instance. mode 0: frame_end with the last byte,
    // mode 1: frame_end one cycle after the last byte, mode 2: gap timeout.
    task automatic send_frame(input int mode);
        int gaps;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i > 0) begin
                gaps = int'($urandom_range(0, 2));
                repeat (gaps) step();
            end
            byte_in   = frame_q[i];
            rx_valid  = 1'b1;
            frame_end = (mode == 0) && (i == frame_q.size() - 1);
            step();
            byte_in   = 8'h00;
            rx_valid  = 1'b0;
            frame_end = 1'b0;
        end
        if (mode == 1) begin
            check("pre_close_valid", {61'd0, v_cam, v_read, v_mem}, 64'd0);
            frame_end = 1'b1;
            step();
            frame_end = 1'b0;
        end else if (mode == 2) begin
            repeat (GAP - 1) step();
            check("gap_boundary_valid", {61'd0, v_cam, v_read, v_mem}, 64'd0);
            check("gap_boundary_err", frame_err, 1'b0);
            step();
        end
    endtask

    // Checks the close result, holds a delivered command with random dropped
    // bytes, then acknowledges it.
    task automatic finish_cmd(input string tag);
        int   hold;
        logic drop;
        check({tag, ".valid"}, {61'd0, v_cam, v_read, v_mem}, {61'd0, exp_v});
        check({tag, ".err"}, frame_err, exp_e);
        if (exp_v != 3'b000) begin
            check({tag, ".instr"}, instruction, exp_op);
            check({tag, ".data"}, data, exp_d);
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                drop     = 1'($urandom_range(0, 1));
                rx_valid = drop;
                byte_in  = 8'($urandom);
                step();
                rx_valid = 1'b0;
                check({tag, ".hold_valid"}, {61'd0, v_cam, v_read, v_mem}, {61'd0, exp_v});
                check({tag, ".hold_data"}, data, exp_d);
                check({tag, ".hold_drop"}, rx_drop, drop);
            end
            drop     = 1'($urandom_range(0, 1));
            out_ack  = 1'b1;
            rx_valid = drop;
            byte_in  = 8'($urandom);
            step();
            out_ack  = 1'b0;
            rx_valid = 1'b0;
            check({tag, ".ack_valid"}, {61'd0, v_cam, v_read, v_mem}, 64'd0);
            check({tag, ".ack_drop"}, rx_drop, drop);
            step();
            check({tag, ".drop_end"}, rx_drop, 1'b0);
        end else begin
            step();
            check({tag, ".err_pulse_end"}, frame_err, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, {61'd0, v_cam, v_read, v_mem}, 64'd0);
        check({tag, ".err"}, frame_err, 1'b0);
        check({tag, ".drop"}, rx_drop, 1'b0);
        check({tag, ".instr"}, instruction, 8'h00);
        check({tag, ".data"}, data, 64'd0);
    endtask

    initial begin
        int len;
        int mode;
        reset        = 1'b1;
        byte_in      = 8'h00;
        rx_valid     = 1'b0;
        frame_end    = 1'b0;
        out_ack      = 1'b0;
        b2_byte      = 8'h00;
        b2_rx_valid  = 1'b0;
        b2_frame_end = 1'b0;
        b2_out_ack   = 1'b0;

        // Reset state.
        repeat (3) @(posedge sysClk);
        #1;
        check_zero("reset");
        check("reset.b2", {b2_cam, b2_read, b2_mem, b2_err, b2_drop, b2_instruction, b2_data}, 64'd0);
        #2 reset = 1'b0;
        step();

        // Mem command closed by a separate frame_end.
        frame_q = '{8'h07, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        model_frame();
        send_frame(1);
        finish_cmd("mem_frame");

        // Short read frame closed by the gap timeout.
        frame_q = '{8'h02, 8'hAA};
        model_frame();
        send_frame(2);
        finish_cmd("short_gap");

        // Unknown opcode.
        frame_q = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        model_frame();
        send_frame(1);
        finish_cmd("unknown_op");

        // Camwrite delivered, then a dropped byte, then a drop coincident with ack.
        frame_q = '{8'h05, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        model_frame();
        send_frame(0);
        check("cam.valid", {61'd0, v_cam, v_read, v_mem}, 64'h4);
        rx_valid = 1'b1;
        byte_in  = 8'h33;
        step();
        rx_valid = 1'b0;
        check("cam.drop", rx_drop, 1'b1);
        check("cam.data_held", data, 64'hA0A1A2A3A4A5A6A7);
        check("cam.valid_held", v_cam, 1'b1);
        step();
        check("cam.drop_end", rx_drop, 1'b0);
        out_ack  = 1'b1;
        rx_valid = 1'b1;
        byte_in  = 8'h44;
        step();
        out_ack  = 1'b0;
        rx_valid = 1'b0;
        check("cam.ack_valid", {61'd0, v_cam, v_read, v_mem}, 64'd0);
        check("cam.ack_drop", rx_drop, 1'b1);
        step();

        // Reset after four bytes of a frame clears held outputs immediately.
        for (int i = 0; i < 4; i++) begin
            byte_in  = 8'h60 + 8'(i);
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_zero("reset_mid_frame");
        #2 reset = 1'b0;
        step();
        step();
        check("post_reset.err", frame_err, 1'b0);

        // Normal frame after reset.
        frame_q = '{8'h01, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        model_frame();
        send_frame(1);
        finish_cmd("after_reset");

        // Reset while a command awaits out_ack.
        frame_q = '{8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        model_frame();
        send_frame(0);
        check("deliver_pre_reset.valid", {61'd0, v_cam, v_read, v_mem}, 64'h1);
        reset = 1'b1;
        #1;
        check_zero("reset_mid_deliver");
        #2 reset = 1'b0;
        step();
        check("post_reset2.err", frame_err, 1'b0);

        // DATA_BYTES=2, GAP_CYCLES=0: frame_end with the third byte.
        b2_byte = 8'h0B; b2_rx_valid = 1'b1; step();
        b2_byte = 8'h01; step();
        b2_byte = 8'h02; b2_frame_end = 1'b1; step();
        b2_rx_valid = 1'b0; b2_frame_end = 1'b0;
        check("b2.valid", {61'd0, b2_cam, b2_read, b2_mem}, 64'h4);
        check("b2.data", b2_data, 16'h0102);
        check("b2.instr", b2_instruction, 8'h0B);
        b2_out_ack = 1'b1; step(); b2_out_ack = 1'b0;
        check("b2.ack", {61'd0, b2_cam, b2_read, b2_mem}, 64'd0);

        // No timeout with GAP_CYCLES=0: a long idle gap leaves the frame open.
        b2_byte = 8'h07; b2_rx_valid = 1'b1; step();
        b2_byte = 8'h01; step();
        b2_rx_valid = 1'b0;
        repeat (20) step();
        check("b2.no_timeout_valid", {61'd0, b2_cam, b2_read, b2_mem}, 64'd0);
        check("b2.no_timeout_err", b2_err, 1'b0);
        b2_frame_end = 1'b1; step(); b2_frame_end = 1'b0;
        check("b2.late_close_valid", {61'd0, b2_cam, b2_read, b2_mem}, LEN_CHECK ? 64'd0 : 64'd1);
        check("b2.late_close_err", b2_err, LEN_CHECK ? 1'b1 : 1'b0);
        check("b2.late_close_data", b2_data, LEN_CHECK ? 16'h0102 : 16'h0100);
        b2_out_ack = 1'b1; b2_rx_valid = 1'b1; b2_byte = 8'h55; step();
        b2_out_ack = 1'b0; b2_rx_valid = 1'b0;
        check("b2.ack2_drop", b2_drop, LEN_CHECK ? 1'b0 : 1'b1);
        step();

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            len  = ($urandom_range(0, 1) == 0) ? DB + 1 : int'($urandom_range(1, DB + 3));
            mode = int'($urandom_range(0, 2));
            if (len == 1 && mode == 0) mode = 1;
            frame_q.delete();
            frame_q.push_back(($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 13)) : 8'($urandom));
            for (int i = 1; i < len; i++) frame_q.push_back(8'($urandom));
            model_frame();
            send_frame(mode);
            finish_cmd("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_frame_assembler.md
CMD_FRAME_ASSEMBLER -- requirements
Module: cmd_frame_assembler

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8, number of payload bytes following the opcode byte (legal range 1..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, number of consecutive idle cycles that closes a frame (0 disables the gap timeout).
REQ-003 SHALL have port sysClk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port byte_in  input  8  byte from the SPI interface.
REQ-006 SHALL have port rx_valid  input  1  byte_in qualifier, one byte per cycle high.
REQ-007 SHALL have port frame_end  input  1  explicit frame close (e.g. chip-select release).
REQ-008 SHALL have port out_ack  input  1  downstream acceptance of the delivered command.
REQ-009 SHALL have port instruction  output  8  opcode (first byte of frame).
REQ-010 SHALL have port data  output  DATA_BYTES*8  payload; first payload byte in the MSBs.
REQ-011 SHALL have ports valid_buffer_for_camwrite, valid_buffer_for_read, valid_buffer_for_mem  output  1 each  class-qualified command valid.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse: bad length or unknown opcode.
REQ-013 SHALL have port rx_drop  output  1  one-cycle pulse: byte received while a command awaits out_ack.

Function
REQ-014 SHALL implement states IDLE, COLLECT, DELIVER.
REQ-015 IDLE: rx_valid high SHALL store byte_in as opcode, set byte count to 1, enter COLLECT; frame_end in IDLE SHALL be ignored.
REQ-016 COLLECT: each rx_valid byte SHALL be placed at payload byte index (count-1), index 0 in data MSBs; count saturates at DATA_BYTES+2.
REQ-017 Bytes beyond DATA_BYTES payload SHALL be discarded and mark the frame over-length.
REQ-018 Gap counter SHALL clear on every accepted byte and increment on each COLLECT cycle without rx_valid.
REQ-019 Frame SHALL close when frame_end is sampled high, or gap counter reaches GAP_CYCLES (if nonzero); a byte with rx_valid in the closing cycle SHALL be included.
REQ-020 At close, opcode classes: 0x00,0x02 read; 0x01,0x03-0x06,0x0B camwrite; 0x07-0x0A mem; anything else unknown.
REQ-021 Known opcode and accepted length: on the closing edge, instruction/data registered, exactly one class valid set, state DELIVER (latency one edge after close condition sampled).
REQ-022 Unknown opcode or rejected length: frame_err pulses one cycle, no valid asserted, state IDLE.
REQ-023 DELIVER: outputs and valid SHALL hold stable until out_ack sampled high; that edge clears valid and returns to IDLE.
REQ-024 DELIVER: any rx_valid byte, including one coincident with out_ack, SHALL be dropped with rx_drop pulsed the following cycle.
REQ-025 Payload bytes not received SHALL read as zero; payload buffer SHALL clear on entry to COLLECT.

Reset
REQ-026 reset high SHALL immediately force IDLE, clear counters, buffer, instruction, data, all valids, frame_err, rx_drop to 0.
REQ-027 Reset mid-frame or mid-DELIVER SHALL discard the command without any valid or error pulse.

Configuration
REQ-028 Macro CMD_FRAME_LEN_CHECK_EN defined: frames with byte count not equal to DATA_BYTES+1 SHALL be rejected per REQ-022.
REQ-029 Macro undefined: short frames SHALL be delivered zero-padded and over-length frames delivered truncated to DATA_BYTES payload.

Verification
REQ-030 Bytes 0x07,0x11..0x18 then frame_end -> valid_buffer_for_mem high next edge, instruction 0x07, data 0x1112131415161718, held until out_ack.
REQ-031 Bytes 0x02,0xAA then idle 4 cycles, macro undefined -> valid_buffer_for_read, data 0xAA00000000000000; macro defined -> frame_err single pulse, no valid.
REQ-032 Opcode 0x0C with 8 payload bytes, frame_end -> frame_err pulse, no valid, returns IDLE.
REQ-033 camwrite 0x05 delivered, out_ack low, rx_valid byte 0x33 -> rx_drop pulse, data unchanged; then out_ack -> valid low, IDLE.
REQ-034 reset asserted after 4 bytes of frame -> all outputs 0 immediately; next full frame 0x01,... delivers normally.
REQ-035 DATA_BYTES=2, GAP_CYCLES=0: bytes 0x0B,0x01,0x02, frame_end coincident with third byte -> camwrite valid, data 0x0102; no timeout close occurs.
